// File: rtl/mem_target_if.sv
// mem_target_if: request/response bundle between an initiator and mem_target.
//   available   : request valid, held by the initiator until busy falls
//   is_write    : 1 = write, 0 = read
//   is_unsigned : reads only; 1 = zero-extend byte/half, 0 = sign-extend
//   op          : access size (00 byte, 01 half, 10 word, 11 invalid)
//   addr        : byte address
//   in          : write data, size taken from the low bits
//   out         : read data
//   busy        : request in progress
//   fault       : the last completed request was rejected
interface mem_target_if;
  logic        available;
  logic        is_write;
  logic        is_unsigned;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] in;
  logic [31:0] out;
  logic        busy;
  logic        fault;

  modport master (
    output available, is_write, is_unsigned, op, addr, in,
    input  out, busy, fault
  );

  modport slave (
    input  available, is_write, is_unsigned, op, addr, in,
    output out, busy, fault
  );
endinterface

// File: rtl/mem_target.sv
// mem_target: word-organised byte-addressable memory target with a fixed
// number of wait states per request.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; aborts any request in flight,
//           storage contents are kept
//   bus   : mem_target_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, power of two, 4..65536
//   WAIT_CYCLES : wait states before completion, 0..15
// Optional feature:
//   MEM_TARGET_BOUNDS_CHECK_EN : when defined, addresses at or beyond
//   4*DEPTH_WORDS fault; otherwise upper address bits are ignored (wrap).
module mem_target #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  mem_target_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_complete;

  logic        r_is_write;
  logic        r_is_unsigned;
  logic [1:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_busy;
  logic        r_fault;
  logic [31:0] r_out;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_fault_cond;
  logic          w_do_write;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_data;
  logic [31:0]   w_rd_word;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [31:0]   w_rd_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.available) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_complete  = 1'b1;
          // a request still asserted is parked in HOLD so it is not re-run
          w_state_nxt = bus.available ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!bus.available) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------- request capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_is_write    <= 1'b0;
      r_is_unsigned <= 1'b0;
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else if (w_accept) begin
      r_is_write    <= bus.is_write;
      r_is_unsigned <= bus.is_unsigned;
      r_op          <= bus.op;
      r_addr        <= bus.addr;
      r_wdata       <= bus.in;
    end
  end

  // ------------------------------------------------------ address decode
  assign w_idx = r_addr[AW+1:2];

`ifdef MEM_TARGET_BOUNDS_CHECK_EN
  logic w_oob;
  assign w_oob = |r_addr[31:AW+2];
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = |r_addr[31:AW+2];
`endif

  always_comb begin
    w_fault_cond = (r_op == 2'b11)
                || ((r_op == 2'b01) && r_addr[0])
                || ((r_op == 2'b10) && (r_addr[1:0] != 2'b00));
`ifdef MEM_TARGET_BOUNDS_CHECK_EN
    w_fault_cond = w_fault_cond || w_oob;
`endif
  end

  // --------------------------------------------------------- write path
  always_comb begin
    w_be        = '0;
    w_lane_data = r_wdata;
    case (r_op)
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be        = 4'b1111;
        w_lane_data = r_wdata;
      end
      default: w_be = '0;
    endcase
  end

  // reset wins over a completion falling on the same edge
  assign w_do_write = reset && w_complete && r_is_write && !w_fault_cond;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------- read path
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_rd_byte = w_rd_word[7:0];
      2'd1:    w_rd_byte = w_rd_word[15:8];
      2'd2:    w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase
    w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    w_rd_data = '0;
    case (r_op)
      2'b00:   w_rd_data = {{24{~r_is_unsigned & w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_rd_data = {{16{~r_is_unsigned & w_rd_half[15]}}, w_rd_half};
      2'b10:   w_rd_data = w_rd_word;
      default: w_rd_data = '0;
    endcase
  end

  // ------------------------------------------------------------ outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_complete) begin
        r_busy  <= 1'b0;
        r_fault <= w_fault_cond;
        if (!r_is_write) r_out <= w_fault_cond ? '0 : w_rd_data;
      end
    end
  end

  assign bus.busy  = r_busy;
  assign bus.fault = r_fault;
  assign bus.out   = r_out;

endmodule

// File: doc/mem_target.md
MEM_TARGET -- requirements
Module: mem_target

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words; the value SHALL be a power of two from 4 to 65536.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before completion; the value SHALL be from 0 to 15.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous reset, active-low.
REQ-005 Port available, input, 1 bit: request valid, held high by the initiator until busy falls.
REQ-006 Port is_write, input, 1 bit: 1 = write request, 0 = read request.
REQ-007 Port is_unsigned, input, 1 bit: on reads, 1 = zero-extend byte/half-word data, 0 = sign-extend it.
REQ-008 Port op, input, 2 bits: access size; 00 = byte, 01 = half-word, 10 = word, 11 = invalid.
REQ-009 Port addr, input, 32 bits: byte address.
REQ-010 Port in, input, 32 bits: write data; the size is taken from the low bits.
REQ-011 Port out, output, 32 bits: read data.
REQ-012 Port busy, output, 1 bit: request in progress.
REQ-013 Port fault, output, 1 bit: the completed request was rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and HOLD.
REQ-015 IDLE with available=1 SHALL, at that edge, latch is_write, is_unsigned, op, addr and in, load counter=WAIT_CYCLES, set busy=1 and enter WAIT; inputs are ignored after the latch.
REQ-016 In WAIT with counter>0, the counter SHALL decrement each cycle.
REQ-017 In WAIT with counter=0, the access SHALL be performed and busy cleared at that edge; busy is therefore high for exactly WAIT_CYCLES+1 cycles.
REQ-018 At completion the next state SHALL be HOLD if available=1, otherwise IDLE.
REQ-019 HOLD SHALL return to IDLE on the first cycle with available=0; a request still high after completion SHALL never be serviced twice.
REQ-020 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; byte lanes SHALL be little-endian.
REQ-021 Write, byte: only lane addr[1:0] SHALL be updated with in[7:0].
REQ-022 Write, half-word: only lanes {addr[1],0} and {addr[1],1} SHALL be updated with in[15:0].
REQ-023 Write, word: all four lanes SHALL be updated with in[31:0].
REQ-024 Read: out SHALL be loaded at completion with the selected byte, half-word or word, extended per is_unsigned to 32 bits.
REQ-025 Write completion SHALL leave out unchanged.
REQ-026 Fault condition: op=11, OR op=01 with addr[0]=1, OR op=10 with addr[1:0]!=0.
REQ-027 On a fault condition, fault=1 SHALL be driven at completion, storage SHALL be unmodified, and out SHALL be loaded with 0 on reads.
REQ-028 fault SHALL otherwise be 0 at completion and SHALL hold its value until the next completion.
REQ-029 Storage SHALL be a single read/write-port array with no initialisation; contents are undefined until written.

Reset
REQ-030 With reset=0 at a rising edge, state SHALL go to IDLE with busy=0, fault=0, out=0 and counter=0.
REQ-031 Reset asserted mid-request SHALL abort the request with no storage write; storage contents SHALL be retained.
REQ-032 After reset, a request with available already high SHALL be accepted on the first edge with reset=1.

Configuration
REQ-033 With MEM_TARGET_BOUNDS_CHECK_EN defined, addr>=4*DEPTH_WORDS SHALL be an additional fault condition handled per REQ-027.
REQ-034 Without MEM_TARGET_BOUNDS_CHECK_EN, the upper addr bits SHALL be ignored and the access SHALL wrap modulo 4*DEPTH_WORDS.

Verification
REQ-035 Write word 0x80FF7F01 @0x10, then read op=00 @0x13 signed -> out=0xFFFFFF80; @0x12 unsigned -> out=0x000000FF.
REQ-036 Write byte 0xAA @0x21 over word 0x11223344 @0x20, then read word @0x20 -> out=0x1122AA44, fault=0.
REQ-037 Read half @0x31 -> fault=1, out=0, storage unchanged; op=11 -> fault=1; word @0x32 -> fault=1.
REQ-038 With WAIT_CYCLES=3 and available held 10 cycles -> busy high exactly 4 cycles, exactly one access, no re-issue until available falls.
REQ-039 Reset pulled low in the 2nd WAIT cycle of a word write of 0xDEADBEEF @0x40 -> busy=0 next cycle, and a subsequent read of @0x40 returns the prior value.
REQ-040 With DEPTH_WORDS=256, write @0x400: with the macro defined -> fault=1; without it -> the data lands at @0x000.
